// File: rtl/fpadd_single.sv
// Two-stage IEEE-754 single-precision adder (flush-to-zero, no denormal output).
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpadd_single (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic [31:0] out
);

`ifdef FPADD_RNE_EN
    localparam logic RNE_ON = 1'b1;
`else
    localparam logic RNE_ON = 1'b0;
`endif

    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic [31:0]       a_r, b_r;
    logic              a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic              a_big_s;
    logic [31:0]       big_s, small_s;
    logic [7:0]        exp_diff_s;
    logic [49:0]       shifted_s;
    logic [26:0]       big_al_s, small_al_s;
    logic [27:0]       sum_s;
    logic [4:0]        lz_s;
    logic [26:0]       norm_s;
    logic signed [9:0] norm_exp_s, round_exp_s;
    logic              round_up_s;
    logic [24:0]       mant_s;
    logic [22:0]       frac_s;
    logic [31:0]       res_s;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    assign a_nan_s  = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
    assign b_nan_s  = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
    assign a_inf_s  = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
    assign b_inf_s  = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
    assign a_zero_s = (a_r[30:23] == 8'h00);
    assign b_zero_s = (b_r[30:23] == 8'h00);

    // Equal magnitudes pick A; only the sign can differ and that case cancels to +0.
    assign a_big_s    = (a_r[30:0] >= b_r[30:0]);
    assign big_s      = a_big_s ? a_r : b_r;
    assign small_s    = a_big_s ? b_r : a_r;
    assign exp_diff_s = big_s[30:23] - small_s[30:23];
    assign shifted_s  = {1'b1, small_s[22:0], 26'd0} >> exp_diff_s;
    assign big_al_s   = {1'b1, big_s[22:0], 3'b000};

    // Align the small operand as {mantissa, guard, round, sticky}
    always_comb begin
        small_al_s = 27'd0;
        if (exp_diff_s >= 8'd26) begin
            small_al_s = 27'd1;
        end else begin
            small_al_s = {shifted_s[49:24], |shifted_s[23:0]};
        end
    end

    assign sum_s = (big_s[31] == small_s[31]) ? ({1'b0, big_al_s} + {1'b0, small_al_s})
                                              : ({1'b0, big_al_s} - {1'b0, small_al_s});

    // Normalize, then round and renormalize on a rounding carry
    always_comb begin
        lz_s        = lzc27(sum_s[26:0]);
        norm_s      = 27'd0;
        norm_exp_s  = 10'sd0;
        round_up_s  = 1'b0;
        mant_s      = 25'd0;
        frac_s      = 23'd0;
        round_exp_s = 10'sd0;
        if (sum_s[27]) begin
            norm_s     = {sum_s[27:2], sum_s[1] | sum_s[0]};
            norm_exp_s = $signed({2'b00, big_s[30:23]}) + 10'sd1;
        end else begin
            norm_s     = sum_s[26:0] << lz_s;
            norm_exp_s = $signed({2'b00, big_s[30:23]}) - $signed({5'd0, lz_s});
        end
        round_up_s = RNE_ON & norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_s     = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
        if (mant_s[24]) begin
            frac_s      = mant_s[23:1];
            round_exp_s = norm_exp_s + 10'sd1;
        end else begin
            frac_s      = mant_s[22:0];
            round_exp_s = norm_exp_s;
        end
    end

    // Special-case priority and final packing
    always_comb begin
        res_s = 32'd0;
        if (a_nan_s || b_nan_s) begin
            res_s = QNAN;
        end else if (a_inf_s && b_inf_s && (a_r[31] != b_r[31])) begin
            res_s = QNAN;
        end else if (a_inf_s) begin
            res_s = a_r;
        end else if (b_inf_s) begin
            res_s = b_r;
        end else if (a_zero_s && b_zero_s) begin
            res_s = {a_r[31] & b_r[31], 31'd0};
        end else if (a_zero_s) begin
            res_s = b_r;
        end else if (b_zero_s) begin
            res_s = a_r;
        end else if (sum_s == 28'd0) begin
            res_s = 32'd0;
        end else if (round_exp_s >= 10'sd255) begin
            res_s = {big_s[31], 8'hFF, 23'd0};
        end else if (round_exp_s <= 10'sd0) begin
            res_s = {big_s[31], 31'd0};
        end else begin
            res_s = {big_s[31], round_exp_s[7:0], frac_s};
        end
    end

    // Operand capture stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= 32'd0;
            b_r <= 32'd0;
        end else begin
            a_r <= reg_A;
            b_r <= reg_B;
        end
    end

    // Result register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= 32'd0;
        end else begin
            out <= res_s;
        end
    end

endmodule

// File: tb/tb_fpadd_single.sv
// Bench for fpadd_single: directed vectors with fixed answers plus random pairs
// checked against an exact-integer reference adder; two-cycle latency tracked in a small pipe.
module tb_fpadd_single;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reg_A, reg_B, out;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pipe_e [2];
    logic        pipe_v [2];
    string       pipe_t [2];

`ifdef FPADD_RNE_EN
    localparam logic [31:0] TIE_SUM = 32'h3F800002;
`else
    localparam logic [31:0] TIE_SUM = 32'h3F800001;
`endif

    fpadd_single dut (.clk(clk), .reset(reset), .reg_A(reg_A), .reg_B(reg_B), .out(out));

    always #5 clk = ~clk;

    // Reference: exact integer sum of the significands, then rounding of that exact value.
    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big, sml;
        logic [65:0] mb, ms, n, q, one;
        int          ea, eb, d, p, e;
        one = 66'd1;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 23'd0) || (eb == 255 && b[22:0] != 23'd0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255 && a[31] != b[31]) return 32'h7FC00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
        else begin big = b; sml = a; end
        d  = int'(big[30:23]) - int'(sml[30:23]);
        mb = 66'({1'b1, big[22:0]}) << 40;
        // A far-away operand only matters as "something nonzero below every rounding bit".
        if (d > 40) ms = 66'd1;
        else ms = 66'({1'b1, sml[22:0]}) << (40 - d);
        n = (big[31] == sml[31]) ? mb + ms : mb - ms;
        if (n == 66'd0) return 32'd0;
        p = 0;
        for (int i = 0; i < 66; i++) if (n[i]) p = i;
        e = int'(big[30:23]) + p - 63;
        q = n >> (p - 23);
`ifdef FPADD_RNE_EN
        begin
            logic [65:0] rem, half;
            rem  = n & ((one << (p - 23)) - 66'd1);
            half = one << (p - 24);
            if (rem > half || (rem == half && q[0])) q = q + 66'd1;
        end
`endif
        if (q[24]) begin q = q >> 1; e = e + 1; end
        if (e >= 255) return {big[31], 8'hFF, 23'd0};
        if (e <= 0) return {big[31], 31'd0};
        return {big[31], 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int         sel;
        logic [7:0] e;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       e = 8'($urandom);
            1:       e = 8'($urandom_range(1, 4));
            2:       e = 8'($urandom_range(250, 254));
            default: e = 8'($urandom_range(100, 150));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_near(input logic [31:0] a);
        int sel, e;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return $urandom;
        if (sel == 1) return {~a[31], a[30:0]};
        e = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [31:0] expv);
        checks++;
        assert (out === expv) else begin
            errors++;
            $error("FAIL %s: out=%h expected=%h", tag, out, expv);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv, input string tag);
        @(negedge clk);
        if (pipe_v[1]) check(pipe_t[1], pipe_e[1]);
        pipe_e[1] = pipe_e[0];
        pipe_v[1] = pipe_v[0];
        pipe_t[1] = pipe_t[0];
        reg_A     = a;
        reg_B     = b;
        pipe_e[0] = expv;
        pipe_v[0] = 1'b1;
        pipe_t[0] = tag;
    endtask

    // After release the first edge still sums the cleared registers, the second the held inputs.
    task automatic release_reset();
        #1;
        reset     = 1'b0;
        pipe_e[1] = 32'd0;
        pipe_v[1] = 1'b1;
        pipe_t[1] = "post_reset_zero";
        pipe_e[0] = fp_ref(reg_A, reg_B);
        pipe_v[0] = 1'b1;
        pipe_t[0] = "post_reset_held";
    endtask

    initial begin
        logic [31:0] a, b;
        reset     = 1'b1;
        reg_A     = 32'd0;
        reg_B     = 32'd0;
        pipe_v[0] = 1'b0;
        pipe_v[1] = 1'b0;
        @(negedge clk);
        check("reset_out", 32'd0);
        release_reset();

        step(32'h3F800000, 32'h3F800000, 32'h40000000, "one_plus_one");
        step(32'h3FC00000, 32'h40100000, 32'h40700000, "1p5_plus_2p25");
        step(32'h40100000, 32'hBFC00000, 32'h3F400000, "2p25_minus_1p5");
        step(32'h3F800000, 32'hBF800000, 32'h00000000, "cancel");
        step(32'h80000000, 32'h80000000, 32'h80000000, "negzero_sum");
        step(32'h00000000, 32'h80000000, 32'h00000000, "pos_neg_zero");
        step(32'h3F800001, 32'h33800000, TIE_SUM,      "round_tie");
        step(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_inf");
        step(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
        step(32'h7FC00000, 32'h3F800000, 32'h7FC00000, "nan_in");
        step(32'h00400000, 32'h3F800000, 32'h3F800000, "denormal_in");
        step(32'hFF800000, 32'h3F800000, 32'hFF800000, "neg_inf");
        step(32'h00800001, 32'h80800000, 32'h00000000, "underflow_flush");
        step(32'hC0000000, 32'h3F800000, 32'hBF800000, "neg_result");

        for (int i = 0; i < 10; i++) begin
            a = rand_op();
            b = rand_near(a);
            step(a, b, fp_ref(a, b), "back_to_back");
        end

        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'd0);
        pipe_v[0] = 1'b0;
        pipe_v[1] = 1'b0;
        @(negedge clk);
        check("reset_hold", 32'd0);
        release_reset();

        for (int i = 0; i < 300; i++) begin
            a = rand_op();
            b = rand_near(a);
            step(a, b, fp_ref(a, b), "random");
        end
        step(32'd0, 32'd0, 32'd0, "drain");
        step(32'd0, 32'd0, 32'd0, "drain");
        step(32'd0, 32'd0, 32'd0, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpadd_single.md
Name: fpadd_single

Overview:
- Pipelined IEEE-754 single-precision floating-point adder: out = reg_A + reg_B.
- Operands are captured in an input register stage and the sum is presented from an output register, so the latency is 2 clocks.
- Standalone arithmetic block with no handshake. A new operand pair may be applied every cycle.

Parameters:
- none (format fixed: 1 sign, 8 exponent bits with bias 127, 23 fraction bits)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- reg_A  input  32  operand A, IEEE-754 single
- reg_B  input  32  operand B, IEEE-754 single
- out  output  32  registered sum, IEEE-754 single

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high. While reset is high, the input registers and out are forced to 32'h00000000.
- Stage 1: at each rising edge, reg_A and reg_B are captured into internal registers A_r and B_r.
- Combinational datapath from A_r/B_r:
  - Unpack each operand and insert the hidden 1.
  - Swap so the operand with the larger magnitude (exponent, then mantissa) is "big".
  - Right-shift the small mantissa by the exponent difference, keeping guard, round and sticky bits. Any shift of 26 or more leaves only sticky.
  - If the signs match, add; otherwise subtract small from big (25-bit result incl. carry).
  - Normalize: on carry-out, shift right 1 and increment the exponent. Otherwise shift left by the leading-zero count and decrement the exponent.
  - Round per the Optional Feature. A rounding carry renormalizes the result, shifting right and incrementing the exponent.
  - Result sign is the sign of the big operand.
- Stage 2: at the next rising edge, the packed result is registered into out. Inputs stable before edge N appear on out after edge N+1, a 2-cycle latency, so out is valid 2 cycles after an input change. Throughput is 1 result per cycle.
- Special cases (priority order):
  1. Either operand NaN (exp=FF, frac≠0) -> 32'h7FC00000.
  2. +Inf + -Inf -> 32'h7FC00000.
  3. Either operand Inf -> that Inf.
  4. Denormal inputs (exp=00) are treated as zero of the same sign.
  5. Zero + x -> x. +0 + -0 -> +0; -0 + -0 -> -0.
  6. Exact cancellation (x + -x) -> +0 (32'h00000000).
  7. Result exponent ≥ 255 -> signed Inf (exp=FF, frac=0).
  8. Result exponent ≤ 0 -> signed zero (flush to zero, no denormal output).
- Reset asserted mid-operation: the pipeline contents are discarded and out = 0 until 2 edges after reset deasserts with valid inputs.
- No status flags are produced.

Optional Feature:
- Macro: FPADD_RNE_EN.
- Defined: round-to-nearest-even. Increment the mantissa when G & (R | S | LSB).
- Not defined: round toward zero (truncation). Guard, round and sticky bits are discarded.
- Overflow gives Inf in both modes.

Test Plan:
- Apply reset for 1 cycle -> out = 00000000 during reset. Then reg_A=3F800000, reg_B=3F800000 -> out=40000000 two cycles later.
- reg_A=3FC00000 (1.5), reg_B=40100000 (2.25) -> out=40700000 (3.75). Also reg_A=40100000, reg_B=BFC00000 -> out=3F400000 (0.75).
- Cancellation: reg_A=3F800000, reg_B=BF800000 -> out=00000000. Also reg_A=80000000, reg_B=80000000 -> out=80000000.
- Rounding tie: reg_A=3F800001, reg_B=33800000 -> out=3F800002 with FPADD_RNE_EN, 3F800001 without.
- Specials:
  - 7F7FFFFF + 7F7FFFFF -> 7F800000.
  - 7F800000 + FF800000 -> 7FC00000.
  - 7FC00000 + 3F800000 -> 7FC00000.
  - 00400000 (denormal) + 3F800000 -> 3F800000.
- Back-to-back: change operands every cycle over 10 vectors -> each sum appears exactly 2 cycles after its operands. Assert reset mid-stream -> out=00000000 immediately (asynchronous).
